// File: rtl/mem_access_unit.sv
// mem_access_unit: registered load/store unit between EXE/MEM and the data-memory port.
// Latches one memory op, runs a req/ack handshake with a timeout, places store bytes on
// the right lanes and extracts/extends load data. Stalls the pipeline until done.
// Optional feature macro: MISALIGN_EXC_EN (trap misaligned LH/LHU/SH/LW/SW instead of issuing).
module mem_access_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter bit          BIG_ENDIAN = 1'b1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  logic [7:0]          op,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [31:0]         wdata,
  output logic                stall,
  output logic [31:0]         rdata,
  output logic                rdata_valid,
  output logic                exc_adel,
  output logic                exc_ades,
  output logic                bus_err,
  output logic [ADDR_W-1:0]   bad_vaddr,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  localparam int unsigned NB        = DATA_W / 8;
  localparam int unsigned OffW      = $clog2(NB);
  localparam int unsigned TimeoutM1 = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam int unsigned CntW      = (TimeoutM1 > 0) ? $clog2(TimeoutM1 + 1) : 1;

  // ALUControl codes of the memory ops
  localparam logic [7:0] OpLb  = 8'hE0;
  localparam logic [7:0] OpLh  = 8'hE1;
  localparam logic [7:0] OpLw  = 8'hE3;
  localparam logic [7:0] OpLbu = 8'hE4;
  localparam logic [7:0] OpLhu = 8'hE5;
  localparam logic [7:0] OpSb  = 8'hE8;
  localparam logic [7:0] OpSh  = 8'hE9;
  localparam logic [7:0] OpSw  = 8'hEB;

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e              state_q;
  logic                op_load_q, op_sext_q;
  logic [2:0]          op_size_q;
  logic [OffW-1:0]     lane_sh_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NB-1:0]       wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CntW-1:0]     cnt_q;
  logic [31:0]         rdata_q;
  logic                rdata_valid_q, exc_adel_q, exc_ades_q;
  logic [ADDR_W-1:0]   bad_vaddr_q;

  logic                op_mem, op_load, op_sext;
  logic [2:0]          op_size;
  logic [OffW-1:0]     off_al, lane_sh;
  logic [NB-1:0]       wen_n;
  logic [DATA_W-1:0]   wdata_n;
  logic [31:0]         rd_lane, rd_ext;
  logic                trap, timeout_hit;

  // Decode the presented op: memory op?, load?, sign-extend?, access size in bytes
  always_comb begin
    op_mem  = 1'b1;
    op_load = 1'b0;
    op_sext = 1'b0;
    op_size = 3'd4;
    case (op)
      OpLb:    begin op_load = 1'b1; op_sext = 1'b1; op_size = 3'd1; end
      OpLbu:   begin op_load = 1'b1; op_size = 3'd1; end
      OpLh:    begin op_load = 1'b1; op_sext = 1'b1; op_size = 3'd2; end
      OpLhu:   begin op_load = 1'b1; op_size = 3'd2; end
      OpLw:    op_load = 1'b1;
      OpSb:    op_size = 3'd1;
      OpSh:    op_size = 3'd2;
      OpSw:    op_size = 3'd4;
      default: op_mem = 1'b0;
    endcase
  end

`ifdef MISALIGN_EXC_EN
  assign trap = ((op_size == 3'd2) && addr[0]) || ((op_size == 3'd4) && (addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  // Lane placement: offset is forced to size alignment, then mapped to a lane shift by endianness
  always_comb begin
    wen_n   = '0;
    wdata_n = '0;
    off_al  = addr[OffW-1:0] & ~OffW'(op_size - 3'd1);
    lane_sh = BIG_ENDIAN ? OffW'(NB - 32'(op_size) - 32'(off_al)) : off_al;
    for (int unsigned i = 0; i < NB; i++) begin
      wen_n[i] = !op_load && (i >= 32'(lane_sh)) && (i < 32'(lane_sh) + 32'(op_size));
      if (op_size == 3'd1) begin
        wdata_n[8*i +: 8] = wdata[7:0];
      end else if (op_size == 3'd2) begin
        wdata_n[8*i +: 8] = wdata[8*(i % 2) +: 8];
      end else begin
        wdata_n[8*i +: 8] = wdata[8*(i % 4) +: 8];
      end
    end
  end

  // Pick the addressed lane out of the read bus and extend it to 32 bits
  always_comb begin
    rd_lane = 32'(mem_rdata >> {lane_sh_q, 3'b000});
    case (op_size_q)
      3'd1:    rd_ext = op_sext_q ? {{24{rd_lane[7]}}, rd_lane[7:0]} : {24'h0, rd_lane[7:0]};
      3'd2:    rd_ext = op_sext_q ? {{16{rd_lane[15]}}, rd_lane[15:0]} : {16'h0, rd_lane[15:0]};
      default: rd_ext = rd_lane;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TimeoutM1));

  // Access FSM with registered results; ack beats timeout when both land in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      op_load_q     <= 1'b0;
      op_sext_q     <= 1'b0;
      op_size_q     <= 3'd0;
      lane_sh_q     <= '0;
      addr_q        <= '0;
      wen_q         <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      exc_adel_q    <= 1'b0;
      exc_ades_q    <= 1'b0;
      bad_vaddr_q   <= '0;
    end else begin
      rdata_valid_q <= 1'b0;
      exc_adel_q    <= 1'b0;
      exc_ades_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (op_valid && op_mem) begin
            if (trap) begin
              exc_adel_q  <= op_load;
              exc_ades_q  <= !op_load;
              bad_vaddr_q <= addr;
            end else begin
              op_load_q <= op_load;
              op_sext_q <= op_sext;
              op_size_q <= op_size;
              lane_sh_q <= lane_sh;
              addr_q    <= addr;
              wen_q     <= wen_n;
              wdata_q   <= wdata_n;
              cnt_q     <= '0;
              state_q   <= StReq;
            end
          end
        end
        StReq: begin
          if (mem_ack) begin
            state_q <= StResp;
            if (op_load_q) begin
              rdata_q       <= rd_ext;
              rdata_valid_q <= 1'b1;
            end
          end else if (timeout_hit) begin
            state_q     <= StResp;
            bad_vaddr_q <= addr_q;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stall is raised combinationally on accept so the op is held from the very first cycle
  assign stall       = !rst && ((state_q == StReq) ||
                                ((state_q == StIdle) && op_valid && op_mem && !trap));
  assign mem_en      = (state_q == StReq);
  assign mem_wen     = (state_q == StReq) ? wen_q : '0;
  assign mem_addr    = {addr_q[ADDR_W-1:OffW], {OffW{1'b0}}};
  assign mem_wdata   = wdata_q;
  assign bus_err     = (state_q == StReq) && !mem_ack && timeout_hit;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign exc_adel    = exc_adel_q;
  assign exc_ades    = exc_ades_q;
  assign bad_vaddr   = bad_vaddr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: a big-endian and a little-endian instance (TIMEOUT=4) share
// stimulus; expected bus/load results are queued at issue time and compared when produced.
module tb_mem_access_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid;
  logic [7:0]    op;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  logic          stall, rdata_valid, exc_adel, exc_ades, bus_err, mem_en;
  logic [31:0]   rdata;
  logic [AW-1:0] bad_vaddr, mem_addr;
  logic [3:0]    mem_wen;
  logic [DW-1:0] mem_wdata;

  logic          stall_le, rdata_valid_le, exc_adel_le, exc_ades_le, bus_err_le, mem_en_le;
  logic [31:0]   rdata_le;
  logic [AW-1:0] bad_vaddr_le, mem_addr_le;
  logic [3:0]    mem_wen_le;
  logic [DW-1:0] mem_wdata_le;

  mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .BIG_ENDIAN(1'b1), .TIMEOUT(4)) u_dut_be (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .exc_adel(exc_adel),
    .exc_ades(exc_ades), .bus_err(bus_err), .bad_vaddr(bad_vaddr), .mem_en(mem_en),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .BIG_ENDIAN(1'b0), .TIMEOUT(4)) u_dut_le (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .addr(addr), .wdata(wdata),
    .stall(stall_le), .rdata(rdata_le), .rdata_valid(rdata_valid_le), .exc_adel(exc_adel_le),
    .exc_ades(exc_ades_le), .bus_err(bus_err_le), .bad_vaddr(bad_vaddr_le),
    .mem_en(mem_en_le), .mem_wen(mem_wen_le), .mem_addr(mem_addr_le),
    .mem_wdata(mem_wdata_le), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  wen;
    logic [3:0]  wen_le;
    logic [31:0] maddr;
    logic [31:0] wd;
  } wr_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_le_q[$];
  wr_t         wr_q[$];

  // Observations collected by run_op
  int            o_stall, o_req, o_rv, o_rv_le, o_berr, o_berr_at, o_adel, o_ades;
  logic [3:0]    o_wen, o_wen_le;
  logic [AW-1:0] o_addr, o_bad;
  logic [31:0]   o_wdata, o_rdata, o_rdata_le;
  bit            o_hung;

  function automatic logic [7:0] mbyte(input logic [31:0] d, input int k, input bit be);
    return be ? d[31-8*k -: 8] : d[8*k +: 8];
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] o, input logic [31:0] a,
                                             input logic [31:0] d, input bit be);
    logic [7:0]  b;
    logic [15:0] h;
    int          k;
    case (o)
      OP_LB, OP_LBU: begin
        b = mbyte(d, int'(a[1:0]), be);
        return (o == OP_LB && b[7]) ? {24'hFFFFFF, b} : {24'h0, b};
      end
      OP_LH, OP_LHU: begin
        k = a[1] ? 2 : 0;
        h = be ? {mbyte(d, k, be), mbyte(d, k + 1, be)} : {mbyte(d, k + 1, be), mbyte(d, k, be)};
        return (o == OP_LH && h[15]) ? {16'hFFFF, h} : {16'h0, h};
      end
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] model_wen(input logic [7:0] o, input logic [31:0] a,
                                           input bit be);
    logic [3:0] m;
    int         sz, k;
    m  = 4'b0;
    sz = (o == OP_SB) ? 1 : (o == OP_SH) ? 2 : 4;
    k  = int'(a[1:0]) & ~(sz - 1);
    for (int j = 0; j < sz; j++) m[be ? 3 - (k + j) : k + j] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [7:0] o, input logic [31:0] w);
    case (o)
      OP_SB:   return {4{w[7:0]}};
      OP_SH:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  // Present one op (held while stalled), ack on REQ cycle ack_wait (0 = never), and record
  // what both DUTs produce until quiet_need consecutive non-stalled cycles have passed.
  task automatic run_op(input logic [7:0] o, input logic [31:0] a, input logic [31:0] w,
                        input logic [31:0] rd, input int ack_wait, input int quiet_need);
    int quiet;
    o_stall = 0; o_req = 0; o_rv = 0; o_rv_le = 0; o_berr = 0; o_berr_at = 0;
    o_adel = 0; o_ades = 0; o_wen = 'x; o_wen_le = 'x; o_addr = 'x; o_wdata = 'x;
    o_rdata = 'x; o_rdata_le = 'x; o_bad = 'x; o_hung = 1'b1;
    op_valid = 1'b1; op = o; addr = a; wdata = w; mem_rdata = rd; mem_ack = 1'b0;
    quiet = 0;
    for (int c = 0; c < 40; c++) begin
      mem_ack = 1'b0;
      if (mem_en) begin
        o_req++;
        if (o_req == 1) begin
          o_wen = mem_wen; o_wen_le = mem_wen_le; o_addr = mem_addr; o_wdata = mem_wdata;
        end
        if (ack_wait != 0 && o_req == ack_wait) mem_ack = 1'b1;
      end
      #1;
      if (stall) o_stall++;
      if (bus_err) begin o_berr++; o_berr_at = o_req; end
      if (rdata_valid) begin o_rv++; o_rdata = rdata; end
      if (rdata_valid_le) begin o_rv_le++; o_rdata_le = rdata_le; end
      if (exc_adel) o_adel++;
      if (exc_ades) o_ades++;
      if (exc_adel || exc_ades) o_bad = bad_vaddr;
      if (stall) quiet = 0;
      else begin op_valid = 1'b0; quiet++; end
      @(posedge clk); #1;
      if (quiet >= quiet_need) begin o_hung = 1'b0; break; end
    end
    mem_ack = 1'b0;
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b0; op = 8'h0; addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({stall, rdata_valid, exc_adel, exc_ades, bus_err, mem_en} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b, want 000000",
                        {stall, rdata_valid, exc_adel, exc_ades, bus_err, mem_en});
    end
    n_vec++;
    if ({rdata, bad_vaddr, mem_addr, mem_wdata, mem_wen} !== '0) begin
      n_bad++; $display("FAIL reset_buses: rdata=%h bad=%h addr=%h wdata=%h wen=%b, want all 0",
                        rdata, bad_vaddr, mem_addr, mem_wdata, mem_wen);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({mem_en, stall} !== 2'b0) begin
      n_bad++; $display("FAIL reset_release_idle: mem_en,stall got %b, want 00", {mem_en, stall});
    end
  endtask

  task automatic test_nonmem();
    run_op(8'h21, 32'h1000, 32'h5, 32'h0, 1, 2);
    n_vec++;
    if (o_stall !== 0 || o_req !== 0) begin
      n_bad++; $display("FAIL nonmem_ignored: stall_cycles=%0d reqs=%0d, want 0/0", o_stall, o_req);
    end
  endtask

  task automatic test_store_lanes();
    logic [7:0]  ops[4]   = '{OP_SB, OP_SH, OP_SW, OP_SB};
    logic [31:0] addrs[4] = '{32'h0000_1001, 32'h0000_1002, 32'h0000_1004, 32'h0000_1003};
    logic [31:0] wds[4]   = '{32'h0000_00A5, 32'h1234_BEEF, 32'hDEAD_BEEF, 32'h7777_775A};
    wr_t e;
    for (int t = 0; t < 4; t++) begin
      wr_q.push_back('{wen: model_wen(ops[t], addrs[t], 1'b1),
                       wen_le: model_wen(ops[t], addrs[t], 1'b0),
                       maddr: {addrs[t][31:2], 2'b00}, wd: model_wdata(ops[t], wds[t])});
      run_op(ops[t], addrs[t], wds[t], 32'h0, 1, 2);
      e = wr_q.pop_front();
      n_vec++;
      if ({o_wen, o_wen_le, o_addr, o_wdata} !== e) begin
        n_bad++; $display("FAIL store_bus[%0d]: got wen=%b/%b addr=%h wd=%h, want %b/%b %h %h",
                          t, o_wen, o_wen_le, o_addr, o_wdata, e.wen, e.wen_le, e.maddr, e.wd);
      end
      n_vec++;
      if (o_stall !== 2 || o_rv !== 0 || o_req !== 1) begin
        n_bad++; $display("FAIL store_timing[%0d]: stall=%0d rv=%0d req=%0d, want 2/0/1",
                          t, o_stall, o_rv, o_req);
      end
    end
  endtask

  task automatic test_load_extend();
    logic [7:0]  ops[5]   = '{OP_LB, OP_LHU, OP_LH, OP_LBU, OP_LW};
    logic [31:0] addrs[5] = '{32'h0000_2003, 32'h0000_2002, 32'h0000_2000, 32'h0000_2001,
                              32'h0000_2000};
    logic [31:0] rds[5]   = '{32'h1122_33F0, 32'h1122_33F0, 32'h8001_7F00, 32'h11F2_33F0,
                              32'hDEAD_BEEF};
    int          acks[5]  = '{3, 2, 1, 1, 2};
    logic [31:0] e, e_le;
    for (int t = 0; t < 5; t++) begin
      exp_q.push_back(model_load(ops[t], addrs[t], rds[t], 1'b1));
      exp_le_q.push_back(model_load(ops[t], addrs[t], rds[t], 1'b0));
      run_op(ops[t], addrs[t], 32'h0, rds[t], acks[t], 2);
      e = exp_q.pop_front();
      e_le = exp_le_q.pop_front();
      n_vec++;
      if (o_rv !== 1 || o_rdata !== e) begin
        n_bad++; $display("FAIL load_be[%0d]: rv=%0d rdata=%h, want 1 %h", t, o_rv, o_rdata, e);
      end
      n_vec++;
      if (o_rv_le !== 1 || o_rdata_le !== e_le) begin
        n_bad++; $display("FAIL load_le[%0d]: rv=%0d rdata=%h, want 1 %h", t, o_rv_le,
                          o_rdata_le, e_le);
      end
      n_vec++;
      if (o_stall !== acks[t] + 1 || o_wen !== 4'b0 || o_addr !== {addrs[t][31:2], 2'b00}) begin
        n_bad++; $display("FAIL load_req[%0d]: stall=%0d wen=%b addr=%h, want %0d 0000 %h", t,
                          o_stall, o_wen, o_addr, acks[t] + 1, {addrs[t][31:2], 2'b00});
      end
    end
  endtask

  task automatic test_timeout();
    run_op(OP_SW, 32'h0000_3000, 32'hCAFE_0001, 32'h0, 0, 2);
    n_vec++;
    if (o_berr !== 1 || o_berr_at !== 4 || o_req !== 4) begin
      n_bad++; $display("FAIL timeout_pulse: pulses=%0d at_req=%0d reqs=%0d, want 1/4/4",
                        o_berr, o_berr_at, o_req);
    end
    n_vec++;
    if (o_stall !== 5 || o_rv !== 0 || o_hung !== 1'b0) begin
      n_bad++; $display("FAIL timeout_release: stall=%0d rv=%0d hung=%0d, want 5/0/0",
                        o_stall, o_rv, o_hung);
    end
    // Ack landing on the last allowed cycle wins over the timeout; counter restarted on accept
    exp_q.push_back(32'h0000_00AB);
    run_op(OP_LBU, 32'h0000_3003, 32'h0, 32'h0000_00AB, 4, 2);
    n_vec++;
    if (o_berr !== 0 || o_rv !== 1 || o_rdata !== exp_q.pop_front()) begin
      n_bad++; $display("FAIL ack_at_limit: berr=%0d rv=%0d rdata=%h, want 0/1 000000ab",
                        o_berr, o_rv, o_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    exp_q.push_back(32'h0000_0011);
    exp_q.push_back(32'h0000_7F00);
    exp_le_q.push_back(32'hFFFF_8001);
    run_op(OP_LBU, 32'h0000_4000, 32'h0, 32'h1122_33F0, 1, 1);
    e = exp_q.pop_front();
    n_vec++;
    if (o_stall !== 2 || o_rv !== 1 || o_rdata !== e) begin
      n_bad++; $display("FAIL b2b_first: stall=%0d rv=%0d rdata=%h, want 2/1 %h",
                        o_stall, o_rv, o_rdata, e);
    end
    run_op(OP_LH, 32'h0000_4002, 32'h0, 32'h8001_7F00, 1, 2);
    e = exp_q.pop_front();
    n_vec++;
    if (o_stall !== 2 || o_rv !== 1 || o_rdata !== e) begin
      n_bad++; $display("FAIL b2b_second: stall=%0d rv=%0d rdata=%h, want 2/1 %h",
                        o_stall, o_rv, o_rdata, e);
    end
    e = exp_le_q.pop_front();
    n_vec++;
    if (o_rdata_le !== e) begin
      n_bad++; $display("FAIL b2b_second_le: rdata=%h, want %h", o_rdata_le, e);
    end
    // Stray acks while idle must not start or complete anything
    mem_ack = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++;
      if ({mem_en, rdata_valid, stall} !== 3'b0) begin
        n_bad++; $display("FAIL idle_ack_ignored: mem_en,rv,stall got %b, want 000",
                          {mem_en, rdata_valid, stall});
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_mid_req_reset();
    logic [31:0] e;
    op_valid = 1'b1; op = OP_SW; addr = 32'h0000_5000; wdata = 32'h0BAD_F00D; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++;
    if (mem_en !== 1'b1) begin
      n_bad++; $display("FAIL mid_req_setup: mem_en=%b, want 1", mem_en);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({mem_en, stall, mem_wen} !== 6'b0) begin
      n_bad++; $display("FAIL mid_req_reset: mem_en,stall,wen got %b, want 000000",
                        {mem_en, stall, mem_wen});
    end
    op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({mem_en, stall} !== 2'b0) begin
      n_bad++; $display("FAIL after_reset_idle: mem_en,stall got %b, want 00", {mem_en, stall});
    end
    exp_q.push_back(32'h1234_5678);
    run_op(OP_LW, 32'h0000_5004, 32'h0, 32'h1234_5678, 1, 2);
    e = exp_q.pop_front();
    n_vec++;
    if (o_rv !== 1 || o_rdata !== e) begin
      n_bad++; $display("FAIL after_reset_load: rv=%0d rdata=%h, want 1 %h", o_rv, o_rdata, e);
    end
  endtask

  task automatic test_misalign();
    run_op(OP_LW, 32'h0000_1002, 32'h0, 32'hCAFE_F00D, 1, 2);
`ifdef MISALIGN_EXC_EN
    n_vec++;
    if (o_req !== 0 || o_stall !== 0 || o_rv !== 0) begin
      n_bad++; $display("FAIL misalign_no_req: reqs=%0d stall=%0d rv=%0d, want 0/0/0",
                        o_req, o_stall, o_rv);
    end
    n_vec++;
    if (o_adel !== 1 || o_ades !== 0 || o_bad !== 32'h0000_1002) begin
      n_bad++; $display("FAIL misalign_exc: adel=%0d ades=%0d bad=%h, want 1/0 00001002",
                        o_adel, o_ades, o_bad);
    end
`else
    n_vec++;
    if (o_req !== 1 || o_addr !== 32'h0000_1000 || o_wen !== 4'b0) begin
      n_bad++; $display("FAIL misalign_issue: reqs=%0d addr=%h wen=%b, want 1 00001000 0000",
                        o_req, o_addr, o_wen);
    end
    n_vec++;
    if (o_rdata !== 32'hCAFE_F00D || o_rdata_le !== 32'hCAFE_F00D || o_adel !== 0) begin
      n_bad++; $display("FAIL misalign_data: be=%h le=%h adel=%0d, want cafef00d cafef00d 0",
                        o_rdata, o_rdata_le, o_adel);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_nonmem();
    test_store_lanes();
    test_load_extend();
    test_timeout();
    test_back_to_back();
    test_mid_req_reset();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
